// File: rtl/dpll_core.sv
// rtl/dpll_core.sv - parametrised digital PLL: NCO accumulator, PD shift filter, lock/holdover FSM
// Tracks rising edges of an asynchronous reference and outputs a dithered NCO phase.
module dpll_core #(
    parameter int PHASE_W   = 32,
    parameter int FRAC_W    = 24,
    parameter int OUT_W     = 18,
    parameter int INCR_W    = 17,
    parameter int ERR_W     = 16,
    parameter int INCR_INIT = 600,
    parameter int INCR_MIN  = 16,
    parameter int INCR_MAX  = 65535,
    parameter int KP_SHIFT  = 9,
    parameter int KD_SHIFT  = 11,
    parameter int LOCK_THR  = 4096,
    parameter int LOCK_CNT  = 8,
    parameter int TIMEOUT   = 131072,
    parameter int DITHER_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    output logic [OUT_W-1:0]  phase_out,
    output logic              locked,
    output logic              holdover,
    output logic [INCR_W-1:0] incr_out,
    output logic [ERR_W-1:0]  err_out,
    output logic              err_valid
);

    localparam int SUM_W = INCR_W + 2;
    localparam int LC_W  = $clog2(LOCK_CNT + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic signed [ERR_W-1:0] E_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic signed [ERR_W-1:0] E_MIN = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(INCR_MIN);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(INCR_MAX);
    localparam logic [PHASE_W-1:0] FRAC_MASK = PHASE_W'((64'd1 << FRAC_W) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK, S_HOLD} state_t;

    state_t state_q, state_d;

    logic                     s1_q, s2_q;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic [INCR_W-1:0]        incr_q, incr_d;
    logic signed [ERR_W-1:0]  ep_last_q, ep_last_d;
    logic signed [ERR_W-1:0]  ed_q, ed_d;
    logic [ERR_W-1:0]         err_q, err_d;
    logic                     err_valid_q;
    logic [LC_W-1:0]          lock_cnt_q, lock_cnt_d;
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
    logic [6:0]               lfsr_q, lfsr_d;
    logic                     pipe_q;
    logic                     locked_q, locked_d;
    logic                     holdover_q, holdover_d;
    logic [OUT_W-1:0]         phase_out_q, phase_out_d;

    logic ev, ev_first, ev_filt, timeout, in_lock, lock_done;

    assign ev      = s1_q & ~s2_q;
    assign timeout = (to_cnt_q == TO_W'(TIMEOUT));

    // Phase error: saturate positive once the phase has run past 2*2pi
    logic [ERR_W-1:0]        ph_field;
    logic signed [ERR_W-1:0] ep;
    logic [ERR_W:0]          ep_ext, ep_abs;

    always_comb begin
        ph_field = phase_q[FRAC_W -: ERR_W];
        if (|phase_q[PHASE_W-1:FRAC_W+1]) begin
            ep = E_MAX;
        end else begin
            ep = ph_field - E_MAX;
        end
        ep_ext  = {ep[ERR_W-1], ep};
        ep_abs  = ep[ERR_W-1] ? (~ep_ext + 1'b1) : ep_ext;
        in_lock = (ep_abs < (ERR_W+1)'(LOCK_THR));
    end

    logic [LC_W-1:0] lc_inc;
    assign lc_inc    = lock_cnt_q + LC_W'(1);
    assign lock_done = in_lock && (lc_inc == LC_W'(LOCK_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ev) state_d = S_ACQ;
            S_ACQ: begin
                if (ev) begin
                    if (lock_done) state_d = S_LOCK;
                end else if (timeout) begin
                    state_d = S_HOLD;
                end
            end
            S_LOCK: begin
                if (ev) begin
                    if (!in_lock) state_d = S_ACQ;
                end else if (timeout) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: if (ev) state_d = S_ACQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ev_first   = ev && (state_q == S_IDLE || state_q == S_HOLD);
        ev_filt    = ev && (state_q == S_ACQ || state_q == S_LOCK);
        locked_d   = (state_d == S_LOCK);
        holdover_d = (state_d == S_HOLD);
    end

    // Loop filter: incr - eP*2^-KP + eD*2^-KD, evaluated the cycle after the edge
    logic signed [ERR_W:0]   ed_diff;
    logic signed [ERR_W-1:0] ed_sat, kp_sh, kd_sh;
    logic signed [SUM_W-1:0] kp_ext, kd_ext, incr_ext, filt_sum;
    logic [INCR_W-1:0]       incr_clamped;

    always_comb begin
        ed_diff = ep_ext - {ep_last_q[ERR_W-1], ep_last_q};
        if (ed_diff[ERR_W] != ed_diff[ERR_W-1]) begin
            ed_sat = ed_diff[ERR_W] ? E_MIN : E_MAX;
        end else begin
            ed_sat = ed_diff[ERR_W-1:0];
        end
        kp_sh    = ep_last_q >>> KP_SHIFT;
        kd_sh    = ed_q >>> KD_SHIFT;
        kp_ext   = {{(SUM_W-ERR_W){kp_sh[ERR_W-1]}}, kp_sh};
        kd_ext   = {{(SUM_W-ERR_W){kd_sh[ERR_W-1]}}, kd_sh};
        incr_ext = {2'b00, incr_q};
        filt_sum = incr_ext - kp_ext + kd_ext;
        if (filt_sum < MIN_S) begin
            incr_clamped = INCR_W'(INCR_MIN);
        end else if (filt_sum > MAX_S) begin
            incr_clamped = INCR_W'(INCR_MAX);
        end else begin
            incr_clamped = filt_sum[INCR_W-1:0];
        end
    end

    logic [PHASE_W:0]   sat_sum;
    logic [PHASE_W-1:0] wrap_sum;
    logic [FRAC_W-1:0]  dither, out_sum;

    always_comb begin
        sat_sum  = {1'b0, phase_q} + (PHASE_W+1)'(incr_q);
        wrap_sum = (phase_q + PHASE_W'(incr_q)) & FRAC_MASK;
        if (ev) begin
            phase_d = '0;
        end else if (state_q == S_HOLD) begin
            phase_d = wrap_sum;
        end else if (sat_sum[PHASE_W]) begin
            phase_d = '1;
        end else begin
            phase_d = sat_sum[PHASE_W-1:0];
        end

        incr_d = incr_q;
        if (pipe_q && state_q != S_HOLD) incr_d = incr_clamped;

        ep_last_d = ep_last_q;
        ed_d      = ed_q;
        err_d     = err_q;
        if (ev_filt) begin
            ep_last_d = ep;
            ed_d      = ed_sat;
            err_d     = ep;
        end else if (ev_first) begin
            ep_last_d = '0;
            ed_d      = '0;
        end

        lock_cnt_d = lock_cnt_q;
        if (ev_filt) begin
            if (!in_lock) begin
                lock_cnt_d = '0;
            end else if (state_q == S_ACQ) begin
                lock_cnt_d = lc_inc;
            end
        end else if (ev_first || state_d == S_HOLD) begin
            lock_cnt_d = '0;
        end

        to_cnt_d = to_cnt_q;
        if (ev || state_q == S_IDLE) begin
            to_cnt_d = '0;
        end else if (!timeout) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        lfsr_d      = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        dither      = (DITHER_EN != 0) ? FRAC_W'(lfsr_q) : '0;
        out_sum     = phase_q[FRAC_W-1:0] + dither;
        phase_out_d = OUT_W'(out_sum >> (FRAC_W - OUT_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            phase_q     <= '0;
            incr_q      <= INCR_W'(INCR_INIT);
            ep_last_q   <= '0;
            ed_q        <= '0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
            lock_cnt_q  <= '0;
            to_cnt_q    <= '0;
            lfsr_q      <= 7'h01;
            pipe_q      <= 1'b0;
            locked_q    <= 1'b0;
            holdover_q  <= 1'b0;
            phase_out_q <= '0;
        end else begin
            s1_q        <= in;
            s2_q        <= s1_q;
            phase_q     <= phase_d;
            incr_q      <= incr_d;
            ep_last_q   <= ep_last_d;
            ed_q        <= ed_d;
            err_q       <= err_d;
            err_valid_q <= ev_filt;
            lock_cnt_q  <= lock_cnt_d;
            to_cnt_q    <= to_cnt_d;
            lfsr_q      <= lfsr_d;
            pipe_q      <= ev_filt;
            locked_q    <= locked_d;
            holdover_q  <= holdover_d;
            phase_out_q <= phase_out_d;
        end
    end

    assign phase_out = phase_out_q;
    assign locked    = locked_q;
    assign holdover  = holdover_q;
    assign incr_out  = incr_q;
    assign err_out   = err_q;
    assign err_valid = err_valid_q;

endmodule

// File: tb/tb_dpll_core.sv
// tb/tb_dpll_core.sv - directed bench for dpll_core with scaled-down widths
module tb_dpll_core;

    localparam int PHASE_W = 16;
    localparam int FRAC_W  = 12;
    localparam int OUT_W   = 5;
    localparam int INCR_W  = 12;
    localparam int ERR_W   = 8;

    logic clk = 1'b0;
    logic rst;
    logic ref_in;

    logic [OUT_W-1:0]  phase_out, phase_out_d;
    logic              locked, locked_d;
    logic              holdover, holdover_d;
    logic [INCR_W-1:0] incr_out, incr_out_d;
    logic [ERR_W-1:0]  err_out, err_out_d;
    logic              err_valid, err_valid_d;

    int errors = 0;
    int checks = 0;
    int dith_bad = 0;
    int dith_ones = 0;
    int dith_samples = 0;

    always #5 clk = ~clk;

    dpll_core #(
        .PHASE_W(PHASE_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .INCR_W(INCR_W), .ERR_W(ERR_W),
        .INCR_INIT(64), .INCR_MIN(8), .INCR_MAX(1000), .KP_SHIFT(2), .KD_SHIFT(3),
        .LOCK_THR(16), .LOCK_CNT(4), .TIMEOUT(2000), .DITHER_EN(0)
    ) u_dut (
        .clk(clk), .rst(rst), .in(ref_in), .phase_out(phase_out), .locked(locked),
        .holdover(holdover), .incr_out(incr_out), .err_out(err_out), .err_valid(err_valid)
    );

    dpll_core #(
        .PHASE_W(PHASE_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .INCR_W(INCR_W), .ERR_W(ERR_W),
        .INCR_INIT(64), .INCR_MIN(8), .INCR_MAX(1000), .KP_SHIFT(2), .KD_SHIFT(3),
        .LOCK_THR(16), .LOCK_CNT(4), .TIMEOUT(2000), .DITHER_EN(1)
    ) u_dith (
        .clk(clk), .rst(rst), .in(ref_in), .phase_out(phase_out_d), .locked(locked_d),
        .holdover(holdover_d), .incr_out(incr_out_d), .err_out(err_out_d), .err_valid(err_valid_d)
    );

    // The dithered instance must track the plain one exactly except for a 0/1 output offset
    always @(negedge clk) begin
        if (!rst) begin
            logic [OUT_W-1:0] diff;
            diff = phase_out_d - phase_out;
            dith_samples++;
            if (diff > 1) dith_bad++;
            if (diff == 1) dith_ones++;
            if (locked_d !== locked || holdover_d !== holdover || incr_out_d !== incr_out ||
                err_out_d !== err_out || err_valid_d !== err_valid) dith_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1ns after the edge that samples ev
    task automatic rise();
        ref_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ref_in = 1'b0;
    endtask

    logic [7:0]  acq_err   [5] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
    logic        acq_valid [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [11:0] acq_incr  [5] = '{12'd64, 12'd64, 12'd64, 12'd65, 12'd65};
    logic        acq_lock  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [11:0] ovf_incr  [4] = '{12'd55, 12'd24, 12'd8, 12'd8};

    // Period-64 reference from IDLE with incr 64: converges to 65 and locks on edge 5
    task automatic run_lock(input string pfx);
        for (int k = 0; k < 5; k++) begin
            wait_cyc(k == 0 ? 10 : 62);
            rise();
            chk($sformatf("%s_valid%0d", pfx, k), 32'(err_valid), 32'(acq_valid[k]));
            chk($sformatf("%s_err%0d", pfx, k), 32'(err_out), 32'(acq_err[k]));
            chk($sformatf("%s_incr%0d", pfx, k), 32'(incr_out), 32'(acq_incr[k]));
            chk($sformatf("%s_lock%0d", pfx, k), 32'(locked), 32'(acq_lock[k]));
            if (k > 0) chk($sformatf("%s_phout%0d", pfx, k), 32'(phase_out), 32'd31);
        end
    endtask

    initial begin
        rst = 1'b1;
        ref_in = 1'b0;
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_holdover", 32'(holdover), 32'd0);
        chk("rst_phase_out", 32'(phase_out), 32'd0);
        chk("rst_incr", 32'(incr_out), 32'd64);
        chk("rst_err", 32'(err_out), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        wait_cyc(3);
        rst = 1'b0;

        run_lock("acq1");
        wait_cyc(1);
        chk("pipe_phout_zero", 32'(phase_out), 32'd0);

        // Asynchronous reset while locked
        rst = 1'b1;
        #1;
        chk("mrst_locked", 32'(locked), 32'd0);
        chk("mrst_holdover", 32'(holdover), 32'd0);
        chk("mrst_phase_out", 32'(phase_out), 32'd0);
        chk("mrst_incr", 32'(incr_out), 32'd64);
        wait_cyc(3);
        rst = 1'b0;

        run_lock("acq2");

        // Reference stops: holdover exactly TIMEOUT+1 cycles after the last ev
        wait_cyc(2000);
        chk("hold_pre", 32'(holdover), 32'd0);
        chk("hold_pre_lock", 32'(locked), 32'd1);
        wait_cyc(1);
        chk("hold_on", 32'(holdover), 32'd1);
        chk("hold_unlock", 32'(locked), 32'd0);
        chk("hold_incr", 32'(incr_out), 32'd65);
        wait_cyc(1);
        chk("hold_phout_sat", 32'(phase_out), 32'd31);
        wait_cyc(1);
        chk("hold_phout_wrap", 32'(phase_out), 32'd0);
        wait_cyc(300);
        chk("hold_incr_frozen", 32'(incr_out), 32'd65);
        chk("hold_no_valid", 32'(err_valid), 32'd0);

        rise();
        chk("hold_exit", 32'(holdover), 32'd0);
        chk("hold_exit_valid", 32'(err_valid), 32'd0);
        chk("hold_exit_lock", 32'(locked), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            wait_cyc(62);
            rise();
            chk($sformatf("relock_valid%0d", k), 32'(err_valid), 32'd1);
            chk($sformatf("relock_err%0d", k), 32'(err_out), 32'd0);
            chk($sformatf("relock_lock%0d", k), 32'(locked), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("relock_incr%0d", k), 32'(incr_out), 32'd65);
        end

        // Early edge (period 40): eP=-48 drops lock, incr = 65 + 12 - 6
        wait_cyc(38);
        rise();
        chk("unlock_err", 32'(err_out), 32'hD0);
        chk("unlock_valid", 32'(err_valid), 32'd1);
        chk("unlock_lock", 32'(locked), 32'd0);
        wait_cyc(1);
        chk("unlock_incr", 32'(incr_out), 32'd71);

        // Period 1500: phase overflows, eP saturates, incr walks down to the clamp
        for (int k = 0; k < 4; k++) begin
            wait_cyc(1497);
            rise();
            chk($sformatf("ovf_err%0d", k), 32'(err_out), 32'h7F);
            chk($sformatf("ovf_lock%0d", k), 32'(locked), 32'd0);
            wait_cyc(1);
            chk($sformatf("ovf_incr%0d", k), 32'(incr_out), 32'(ovf_incr[k]));
        end

        chk("dither_range", 32'(dith_bad), 32'd0);
        chk("dither_active", 32'(dith_ones > 0), 32'd1);
        chk("dither_not_const", 32'(dith_ones < dith_samples), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
